uart_tx_fifo: RTL and testbench

Byte buffer and transmit sequencer placed directly upstream of the UART transmitter. It accepts bytes from a producer such as the CPU/MMIO bus or a test-pattern generator, stores them in a circular FIFO, and drains them one at a time. Draining drives the transmitter's one-cycle send strobe and data byte, then waits on its busy flag. The producer never has to watch the serial timing.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo_if.sv | 45 ++++
 rtl/uart_tx_fifo_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-FIFO drain state type.
// Reused by the transmitter for its baud timing.
package uart_pkg;

   localparam int DATA_W       = 8;
   localparam int CLK_HZ       = 50_000_000;
   localparam int BAUD         = 115_200;
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } tx_fifo_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer and transmitter signals of uart_tx_fifo, plus the drain-state debug view.
// UART_TX_FIFO_OVF_EN adds the ovf_clr/overflow pair.
interface uart_tx_fifo_if #(
   parameter int DEPTH = 16
);
   import uart_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   // Handshake: a byte is taken on any rising clk edge where wr_en=1 and full=0;
   // tx_send is a single-cycle strobe, and the next one waits for tx_busy to fall.
   logic [DATA_W-1:0] wr_data;
   logic              wr_en;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] tx_data;
   logic              tx_send;
   logic              tx_busy;
   logic              idle;
   tx_fifo_state_t    dbg_state;
`ifdef UART_TX_FIFO_OVF_EN
   logic              ovf_clr;
   logic              overflow;

   modport slave (
      input  wr_data, wr_en, tx_busy, ovf_clr,
      output full, empty, count, tx_data, tx_send, idle, dbg_state, overflow
   );
   modport master (
      output wr_data, wr_en, tx_busy, ovf_clr,
      input  full, empty, count, tx_data, tx_send, idle, dbg_state, overflow
   );
`else
   modport slave (
      input  wr_data, wr_en, tx_busy,
      output full, empty, count, tx_data, tx_send, idle, dbg_state
   );
   modport master (
      output wr_data, wr_en, tx_busy,
      input  full, empty, count, tx_data, tx_send, idle, dbg_state
   );
`endif

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: generic circular buffer with occupancy count and full/empty flags.
// A write into a full buffer is ignored, even when a read happens in the same cycle.
module sync_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_wr_en,
   input  logic [DATA_W-1:0]          i_wr_data,
   input  logic                       i_rd_en,
   output logic [DATA_W-1:0]          o_rd_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              w_full;
   logic              w_empty;
   logic              w_wr;
   logic              w_rd;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_wr    = i_wr_en && !w_full;
   assign w_rd    = i_rd_en && !w_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Contents need no reset: the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: pops one byte, strobes tx_send, then tracks tx_busy.
// UART_TX_FIFO_OVF_EN adds a sticky overflow flag for writes dropped while full.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input logic           clk,
   input logic           rst_n,
   uart_tx_fifo_if.slave bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   tx_fifo_state_t    r_state;
   tx_fifo_state_t    w_next_state;
   logic [TW-1:0]     r_to;
   logic [TW-1:0]     w_to_next;
   logic [DATA_W-1:0] r_tx_data;
   logic [DATA_W-1:0] w_tx_data_next;
   logic              w_pop;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_wr_en   (bus.wr_en),
      .i_wr_data (bus.wr_data),
      .i_rd_en   (w_pop),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_to      <= '0;
         r_tx_data <= '0;
      end else begin
         r_state   <= w_next_state;
         r_to      <= w_to_next;
         r_tx_data <= w_tx_data_next;
      end
   end

   // A busy transmitter in S_IDLE means a foreign transfer: hold the head until it ends.
   always_comb begin
      w_next_state   = r_state;
      w_to_next      = r_to;
      w_tx_data_next = r_tx_data;
      w_pop          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && !bus.tx_busy) begin
               w_pop          = 1'b1;
               w_tx_data_next = w_rd_data;
               w_next_state   = S_SEND;
            end
         end
         S_SEND: begin
            w_to_next    = '0;
            w_next_state = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               w_next_state = S_WAIT_DONE;
            end else if (r_to == TW'(BUSY_TIMEOUT - 1)) begin
               w_next_state = S_IDLE;
            end else begin
               w_to_next = r_to + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign bus.tx_send   = (r_state == S_SEND);
   assign bus.tx_data   = r_tx_data;
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
   assign bus.count     = w_count;
   assign bus.idle      = w_empty && (r_state == S_IDLE);
   assign bus.dbg_state = r_state;

`ifdef UART_TX_FIFO_OVF_EN
   logic r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (bus.wr_en && w_full) begin
         r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   assign bus.overflow = r_overflow;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: queue reference model, transmitter busy model, directed scenarios.
// Build with UART_TX_FIFO_OVF_EN to include the overflow flag.
module tb_uart_tx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int BT    = 4;
   localparam int M_NORMAL = 0;
   localparam int M_HOLD   = 1;
   localparam int M_STUCK0 = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DEPTH(DEPTH)) bif ();

   uart_tx_fifo #(
      .DEPTH        (DEPTH),
      .DATA_W       (8),
      .BUSY_TIMEOUT (BT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Transmitter model: busy starts the cycle after a strobe and lasts 1..5 cycles.
   int bmode = M_NORMAL;
   int busy_len_fix = 0;
   int busy_left = 0;
   bit busy_pend = 0;
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         busy_left = 0;
         busy_pend = 0;
      end else begin
         if (busy_left > 0) busy_left--;
         if (busy_pend) begin
            busy_left = (busy_len_fix > 0) ? busy_len_fix : int'($urandom_range(1, 5));
            busy_pend = 0;
         end
         if (bif.tx_send && bmode != M_STUCK0) busy_pend = 1;
      end
      bif.tx_busy = (bmode == M_HOLD) || (busy_left > 0);
   end

   // Reference model and scoreboard, evaluated mid-cycle.
   logic [7:0] exp_q[$];
   logic [7:0] sent_q[$];
   int         strobe_q[$];
   bit         pend_wr = 0;
   logic [7:0] pend_data = '0;
   bit         pend_clr = 0;
   bit         exp_ovf = 0;
   logic [7:0] last_data = '0;
   bit         prev_send = 0;
   bit         prev_busy = 0;

   always @(negedge clk) begin : mon
      int size_prev;
      if (!rst_n) begin
         exp_q.delete();
         pend_wr   = 0;
         pend_clr  = 0;
         exp_ovf   = 0;
         last_data = '0;
         prev_send = 0;
         prev_busy = 0;
      end else begin
         size_prev = exp_q.size();
         if (bif.tx_send) begin
            if (exp_q.size() == 0) check("pop_from_empty", 1, 0);
            else last_data = exp_q.pop_front();
            check("strobe_data", bif.tx_data, last_data);
            check("strobe_spacing", prev_send, 0);
            check("strobe_after_busy", prev_busy, 0);
            check("idle_during_send", bif.idle, 0);
            strobe_q.push_back(cyc);
            sent_q.push_back(bif.tx_data);
         end
         if (pend_wr && size_prev < DEPTH) exp_q.push_back(pend_data);
         if (pend_wr && size_prev == DEPTH) exp_ovf = 1;
         else if (pend_clr) exp_ovf = 0;
         check("count", bif.count, exp_q.size());
         check("empty", bif.empty, exp_q.size() == 0);
         check("full", bif.full, exp_q.size() == DEPTH);
         check("tx_data_hold", bif.tx_data, last_data);
`ifdef UART_TX_FIFO_OVF_EN
         check("overflow", bif.overflow, exp_ovf);
         pend_clr = bif.ovf_clr;
`endif
         pend_wr   = bif.wr_en;
         pend_data = bif.wr_data;
         prev_send = bif.tx_send;
         prev_busy = bif.tx_busy;
      end
   end

   task automatic step(input bit we, input logic [7:0] d);
      @(posedge clk);
      #1;
      bif.wr_en   = we;
      bif.wr_data = d;
   endtask

   task automatic wait_idle(input int max);
      bit ok = 0;
      for (int i = 0; i < max; i++) begin
         step(0, 8'h00);
         if (bif.idle && exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check("idle_reached", ok, 1);
   endtask

   task automatic wait_sent(input int n, input int max);
      for (int i = 0; i < max && sent_q.size() < n; i++) step(0, 8'h00);
      check("sent_count", sent_q.size(), n);
   endtask

   function automatic logic [7:0] rnd_byte();
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      if (d == 8'hAA) d = 8'h5A;
      return d;
   endfunction

   initial begin : wdog
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int wr_cyc;
      int gap;
      int found;
      logic [7:0] x;
      rst_n       = 1'b0;
      bif.wr_en   = 1'b0;
      bif.wr_data = '0;
`ifdef UART_TX_FIFO_OVF_EN
      bif.ovf_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset, then quiet for 100 cycles
      @(negedge clk);
      check("rst_empty", bif.empty, 1);
      check("rst_count", bif.count, 0);
      check("rst_send", bif.tx_send, 0);
      check("rst_idle", bif.idle, 1);
      check("rst_tx_data", bif.tx_data, 0);
      repeat (100) step(0, 8'h00);
      check("quiet_strobes", strobe_q.size(), 0);

      // Single byte, one-cycle busy
      busy_len_fix = 1;
      step(1, 8'h55);
      wr_cyc = cyc;
      repeat (20) step(0, 8'h00);
      check("single_count", sent_q.size(), 1);
      check("single_data", sent_q[0], 8'h55);
      check("single_latency", strobe_q[0] - wr_cyc, 2);
      @(negedge clk);
      check("single_idle", bif.idle, 1);

      // Burst 0x01..0x10 with the transmitter holding busy
      sent_q.delete();
      strobe_q.delete();
      busy_len_fix = 0;
      bmode = M_HOLD;
      step(0, 8'h00);
      for (int i = 1; i <= DEPTH; i++) step(1, 8'(i));
      step(0, 8'h00);
      @(negedge clk);
      check("burst_full", bif.full, 1);
      check("burst_count16", bif.count, DEPTH);
      bmode = M_NORMAL;
      wait_sent(DEPTH, 400);
      for (int i = 0; i < DEPTH && i < sent_q.size(); i++) check("burst_order", sent_q[i], i + 1);
      wait_idle(100);
      check("burst_drained", bif.count, 0);

      // Overflow while the drain is stalled
      sent_q.delete();
      bmode = M_HOLD;
      step(0, 8'h00);
      for (int i = 0; i < DEPTH; i++) step(1, rnd_byte());
      step(1, 8'hAA);
      step(0, 8'h00);
      @(negedge clk);
      check("ovf_count", bif.count, DEPTH);
`ifdef UART_TX_FIFO_OVF_EN
      check("ovf_set", bif.overflow, 1);
      repeat (3) step(0, 8'h00);
      @(negedge clk);
      check("ovf_sticky", bif.overflow, 1);
      step(0, 8'h00);
      bif.ovf_clr = 1'b1;
      step(0, 8'h00);
      bif.ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_cleared", bif.overflow, 0);
      step(1, 8'hAA);
      bif.ovf_clr = 1'b1;
      step(0, 8'h00);
      bif.ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf_set_wins", bif.overflow, 1);
`endif
      bmode = M_NORMAL;
      wait_sent(DEPTH, 400);
      found = 0;
      foreach (sent_q[i]) if (sent_q[i] == 8'hAA) found++;
      check("ovf_byte_never_sent", found, 0);
      wait_idle(100);

      // Write in the same cycle as a pop
      sent_q.delete();
      bmode = M_HOLD;
      step(0, 8'h00);
      for (int i = 0; i < 3; i++) step(1, rnd_byte());
      step(0, 8'h00);
      @(negedge clk);
      check("simul_pre_count", bif.count, 3);
      x = rnd_byte();
      @(posedge clk);
      #1;
      bmode       = M_NORMAL;
      bif.wr_en   = 1'b1;
      bif.wr_data = x;
      step(0, 8'h00);
      @(negedge clk);
      check("simul_count", bif.count, 3);
      wait_sent(4, 200);
      check("simul_fourth", sent_q[3], x);
      wait_idle(100);

      // Transmitter never raises busy: handshake abandoned, next byte still sent
      sent_q.delete();
      strobe_q.delete();
      bmode = M_STUCK0;
      step(1, rnd_byte());
      step(1, rnd_byte());
      step(0, 8'h00);
      wait_sent(2, 50);
      gap = strobe_q[1] - strobe_q[0];
      check("timeout_gap", (gap >= BT + 1) && (gap <= BT + 2), 1);
      wait_idle(50);
      bmode = M_NORMAL;

      // Asynchronous reset while waiting for the transfer to finish
      busy_len_fix = 8;
      step(1, rnd_byte());
      step(1, rnd_byte());
      step(1, rnd_byte());
      for (int i = 0; i < 30 && bif.dbg_state != S_WAIT_DONE; i++) step(0, 8'h00);
      check("reach_wait_done", bif.dbg_state == S_WAIT_DONE, 1);
      check("pre_reset_count", bif.count, 2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_send", bif.tx_send, 0);
      check("mid_rst_count", bif.count, 0);
      check("mid_rst_empty", bif.empty, 1);
      check("mid_rst_idle", bif.idle, 1);
      check("mid_rst_tx_data", bif.tx_data, 0);
      check("mid_rst_state", bif.dbg_state == S_IDLE, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      sent_q.delete();
      repeat (20) step(0, 8'h00);
      check("post_rst_no_send", sent_q.size(), 0);
      busy_len_fix = 0;

      // Random traffic with occasional stalls and clears
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 99) == 0) bmode = (bmode == M_HOLD) ? M_NORMAL : M_HOLD;
         step($urandom_range(0, 99) < 40, 8'($urandom_range(0, 255)));
`ifdef UART_TX_FIFO_OVF_EN
         bif.ovf_clr = ($urandom_range(0, 19) == 0);
`endif
      end
      bmode = M_NORMAL;
`ifdef UART_TX_FIFO_OVF_EN
      bif.ovf_clr = 1'b0;
`endif
      wait_idle(3000);
      check("final_model_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
